// File: rtl/vector_instruction_issuer_if.sv
// Host and processor facing signals of vector_instruction_issuer.
// master = host/processor side, slave = the issuer.
interface vector_instruction_issuer_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [12:0]      prog_data;
    logic             prog_valid;
    logic             prog_ready;
    logic             start;
    logic [12:0]      instruction;
    logic             instr_valid;
    logic             busy;
    logic             done;
    logic [7:0]       issued_count;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output prog_data, prog_valid, start,
        input  prog_ready, instruction, instr_valid, busy, done, issued_count, fifo_count
    );

    modport slave (
        input  prog_data, prog_valid, start,
        output prog_ready, instruction, instr_valid, busy, done, issued_count, fifo_count
    );
endinterface

// File: rtl/vector_instruction_issuer.sv
// Instruction FIFO plus issue sequencer: each popped instruction is held on
// the output for an opcode-dependent number of clocks, back to back.
module vector_instruction_issuer #(
    parameter int DEPTH     = 8,
    parameter int LAT_LOAD  = 2,
    parameter int LAT_STORE = 2,
    parameter int LAT_ADD   = 3,
    parameter int LAT_MUL   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    vector_instruction_issuer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LAT_LS  = (LAT_LOAD > LAT_STORE) ? LAT_LOAD : LAT_STORE;
    localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_MAX = (LAT_LS > LAT_AM) ? LAT_LS : LAT_AM;
    localparam int HOLD_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [12:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [7:0]        issued_q, issued_d;
    logic              push, pop, not_empty;
    logic [12:0]       head;
    logic [12:0]       fifo_mem [DEPTH];

    // Extra cycles after the ISSUE cycle that an opcode stays on the output.
    function automatic logic [HOLD_W-1:0] hold_cycles(input logic [1:0] op);
        case (op)
            2'b00:   return HOLD_W'(LAT_LOAD - 1);
            2'b01:   return HOLD_W'(LAT_STORE - 1);
            2'b10:   return HOLD_W'(LAT_ADD - 1);
            default: return HOLD_W'(LAT_MUL - 1);
        endcase
    endfunction

    assign not_empty = (count_q != '0);
    assign push      = bus.prog_valid && (count_q != CNT_W'(DEPTH));
    assign head      = fifo_mem[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d  = state_q;
        hold_d   = hold_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        issued_d = issued_q;
        pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (not_empty) pop = 1'b1;
                    else           done_d = 1'b1;
                end
            end
            ISSUE, HOLD: begin
                if (hold_q != '0) begin
                    hold_d  = hold_q - HOLD_W'(1);
                    state_d = HOLD;
                end else if (not_empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output register only ever loads on a pop, so it cannot change mid-hold.
        if (pop) begin
            instr_d  = head;
            valid_d  = 1'b1;
            hold_d   = hold_cycles(head[12:11]);
            state_d  = ISSUE;
            issued_d = issued_q + 8'd1;
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= 13'h0000;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            issued_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            hold_q   <= hold_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            issued_q <= issued_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.prog_data;
    end

    assign bus.prog_ready   = (count_q != CNT_W'(DEPTH));
    assign bus.instruction  = instr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.issued_count = issued_q;
    assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_vector_instruction_issuer.sv
// Self-checking bench: a negedge monitor groups the output stream into
// (instruction, held cycles) segments, compared against a queue of accepted pushes.
module tb_vector_instruction_issuer;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SNAP_W = 13 + 3 + 8 + CNT_W + 1;
    localparam logic [SNAP_W-1:0] RESET_SNAP = {13'h0000, 3'b000, 8'h00, CNT_W'(0), 1'b1};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [12:0] exp_q[$];
    logic [12:0] seg_instr[$];
    int          seg_len[$];
    int          done_cnt     = 0;
    int          valid_rises  = 0;
    int          valid_cycles = 0;
    int          glitches     = 0;
    logic        prev_valid   = 1'b0;
    logic [7:0]  prev_cnt     = 8'd0;
    logic [12:0] prev_instr   = 13'h0;

    always #5 clk = ~clk;

    vector_instruction_issuer_if #(.DEPTH(DEPTH)) bus ();

    vector_instruction_issuer #(
        .DEPTH(DEPTH), .LAT_LOAD(2), .LAT_STORE(2), .LAT_ADD(3), .LAT_MUL(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_cnt   = 8'd0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.instr_valid) begin
                valid_cycles++;
                if (!prev_valid) valid_rises++;
                if (!prev_valid || bus.issued_count != prev_cnt) begin
                    seg_instr.push_back(bus.instruction);
                    seg_len.push_back(1);
                end else begin
                    seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
                    if (bus.instruction !== prev_instr) glitches++;
                end
            end
            prev_valid = bus.instr_valid;
            prev_cnt   = bus.issued_count;
            prev_instr = bus.instruction;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input logic [12:0] ins);
        case (ins[12:11])
            2'b00:   return 2;
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 3;
        endcase
    endfunction

    // Segments observed since base versus the model queue; returns the number of discrepancies.
    function automatic int seg_errors(input int base);
        int e = 0;
        if (seg_instr.size() - base != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size() && base + i < seg_instr.size(); i++) begin
            if (seg_instr[base+i] !== exp_q[i]) e++;
            if (seg_len[base+i] != lat_of(exp_q[i])) e++;
        end
        return e;
    endfunction

    function automatic logic [SNAP_W-1:0] snap();
        return {bus.instruction, bus.instr_valid, bus.busy, bus.done,
                bus.issued_count, bus.fifo_count, bus.prog_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [12:0] d, output bit acc);
        bus.prog_valid = 1'b1;
        bus.prog_data  = d;
        acc            = bus.prog_ready;
        tick();
        bus.prog_valid = 1'b0;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (snap() !== RESET_SNAP) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", snap(), RESET_SNAP);
        end
        #10 reset = 1'b1;
        tick();
        tick();
        checks++;
        if (snap() !== RESET_SNAP) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", snap(), RESET_SNAP);
        end
    endtask

    task automatic test_single_load();
        bit acc;
        int base = seg_instr.size();
        int d0   = done_cnt;
        push_word(13'h0205, acc);
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            logic [15:0] got, want;
            got  = {bus.instruction, bus.instr_valid, bus.busy, bus.done};
            want = (c < 2) ? {13'h0205, 3'b110} : (c == 2) ? {13'h0205, 3'b001} : {13'h0205, 3'b000};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single_load cycle %0d: got %h expected %h", c, got, want);
            end
            tick();
        end
        checks++;
        if (bus.issued_count !== 8'd1 || done_cnt - d0 != 1 || seg_errors(base) != 0) begin
            failures++;
            $display("FAIL single_load_summary: count %0d dones %0d segerr %0d expected 1 1 0",
                     bus.issued_count, done_cnt - d0, seg_errors(base));
        end
        exp_q.delete();
    endtask

    task automatic test_mixed_latency();
        bit acc, ok;
        int base = seg_instr.size();
        int d0 = done_cnt, r0 = valid_rises, v0 = valid_cycles, g0 = glitches;
        logic [7:0] c0 = bus.issued_count;
        push_word(13'h0000, acc);
        push_word(13'h0A10, acc);
        push_word(13'h1000, acc);
        push_word(13'h1800, acc);
        pulse_start();
        wait_done(60, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mixed_timeout: got no done expected done"); end
        checks++;
        if (seg_errors(base) != 0 || seg_instr.size() - base != 4) begin
            failures++;
            $display("FAIL mixed_segments: got %0d errors over %0d segs expected 0 over 4",
                     seg_errors(base), seg_instr.size() - base);
        end
        checks++;
        if (valid_cycles - v0 != 10 || valid_rises - r0 != 1 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL mixed_valid: got cycles %0d rises %0d dones %0d expected 10 1 1",
                     valid_cycles - v0, valid_rises - r0, done_cnt - d0);
        end
        checks++;
        if (8'(bus.issued_count - c0) !== 8'd4 || glitches != g0) begin
            failures++;
            $display("FAIL mixed_count: got %0d glitches %0d expected 4 0",
                     8'(bus.issued_count - c0), glitches - g0);
        end
        exp_q.delete();
    endtask

    task automatic test_fifo_full_wrap();
        bit acc, ok;
        int base = seg_instr.size();
        int d0 = done_cnt, r0 = valid_rises;
        for (int i = 0; i < 8; i++) push_word(13'($urandom), acc);
        checks++;
        if (bus.fifo_count !== CNT_W'(8) || bus.prog_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_flags: got count %0d ready %b expected 8 0", bus.fifo_count, bus.prog_ready);
        end
        push_word(13'h1FFF, acc);
        checks++;
        if (acc !== 1'b0 || bus.fifo_count !== CNT_W'(8)) begin
            failures++;
            $display("FAIL full_reject: got acc %b count %0d expected 0 8", acc, bus.fifo_count);
        end
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) push_word(13'($urandom), acc);
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_timeout: got no done expected done"); end
        checks++;
        if (seg_instr.size() - base != 13 || seg_errors(base) != 0) begin
            failures++;
            $display("FAIL full_order: got %0d segs %0d errors expected 13 0",
                     seg_instr.size() - base, seg_errors(base));
        end
        checks++;
        if (done_cnt - d0 != 1 || valid_rises - r0 != 1 || bus.fifo_count !== CNT_W'(0)) begin
            failures++;
            $display("FAIL full_end: got dones %0d rises %0d count %0d expected 1 1 0",
                     done_cnt - d0, valid_rises - r0, bus.fifo_count);
        end
        exp_q.delete();
    endtask

    task automatic test_simul_push_pop();
        bit acc, ok;
        int base = seg_instr.size();
        for (int i = 0; i < 3; i++) push_word(13'($urandom), acc);
        bus.start      = 1'b1;
        bus.prog_valid = 1'b1;
        bus.prog_data  = 13'h1ABC;
        tick();
        bus.start      = 1'b0;
        bus.prog_valid = 1'b0;
        exp_q.push_back(13'h1ABC);
        checks++;
        if (bus.fifo_count !== CNT_W'(3) || bus.instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL simul_count: got count %0d valid %b expected 3 1", bus.fifo_count, bus.instr_valid);
        end
        wait_done(100, ok);
        checks++;
        if (!ok || seg_errors(base) != 0 || seg_instr[seg_instr.size()-1] !== 13'h1ABC) begin
            failures++;
            $display("FAIL simul_order: got done %b errors %0d last %h expected 1 0 1abc",
                     ok, seg_errors(base), seg_instr[seg_instr.size()-1]);
        end
        exp_q.delete();
    endtask

    // A push landing on the last held cycle of an empty queue must not extend the run.
    task automatic test_late_push();
        bit acc, ok;
        int base = seg_instr.size();
        push_word(13'h0123, acc);
        pulse_start();
        tick();
        push_word(13'h0ABC, acc);
        checks++;
        if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.fifo_count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL late_push_end: got done %b valid %b count %0d expected 1 0 1",
                     bus.done, bus.instr_valid, bus.fifo_count);
        end
        pulse_start();
        wait_done(40, ok);
        checks++;
        if (!ok || seg_errors(base) != 0) begin
            failures++;
            $display("FAIL late_push_order: got done %b errors %0d expected 1 0", ok, seg_errors(base));
        end
        exp_q.delete();
    endtask

    task automatic test_start_empty_and_busy();
        bit acc, ok;
        int base, d0, r0;
        base = seg_instr.size();
        pulse_start();
        checks++;
        if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_start: got done %b valid %b busy %b expected 1 0 0",
                     bus.done, bus.instr_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || seg_instr.size() != base) begin
            failures++;
            $display("FAIL empty_start_pulse: got done %b segs %0d expected 0 0", bus.done, seg_instr.size() - base);
        end
        d0 = done_cnt;
        r0 = valid_rises;
        push_word(13'($urandom), acc);
        push_word(13'($urandom), acc);
        pulse_start();
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        wait_done(40, ok);
        checks++;
        if (!ok || seg_errors(base) != 0 || done_cnt - d0 != 1 || valid_rises - r0 != 1) begin
            failures++;
            $display("FAIL busy_start: got done %b errors %0d dones %0d rises %0d expected 1 0 1 1",
                     ok, seg_errors(base), done_cnt - d0, valid_rises - r0);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        bit acc, ok;
        for (int round = 0; round < 5; round++) begin
            int base = seg_instr.size();
            int n = int'($urandom_range(1, 6));
            int k = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) push_word(13'($urandom), acc);
            pulse_start();
            for (int i = 0; i < k; i++) push_word(13'($urandom), acc);
            wait_done(200, ok);
            checks++;
            if (!ok || seg_errors(base) != 0) begin
                failures++;
                $display("FAIL random_round %0d: got done %b errors %0d expected 1 0", round, ok, seg_errors(base));
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midrun();
        bit acc;
        int base;
        for (int i = 0; i < 3; i++) push_word(13'($urandom), acc);
        pulse_start();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (snap() !== RESET_SNAP) begin
            failures++;
            $display("FAIL reset_midrun: got %h expected %h", snap(), RESET_SNAP);
        end
        #3 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        base = seg_instr.size();
        pulse_start();
        checks++;
        if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.fifo_count !== CNT_W'(0)) begin
            failures++;
            $display("FAIL reset_then_start: got done %b valid %b count %0d expected 1 0 0",
                     bus.done, bus.instr_valid, bus.fifo_count);
        end
        tick();
        checks++;
        if (seg_instr.size() != base || bus.issued_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_no_issue: got segs %0d count %0d expected 0 0",
                     seg_instr.size() - base, bus.issued_count);
        end
    endtask

    initial begin
        bus.prog_data  = 13'h0;
        bus.prog_valid = 1'b0;
        bus.start      = 1'b0;
        test_reset();
        test_single_load();
        test_mixed_latency();
        test_fifo_full_wrap();
        test_simul_push_pop();
        test_late_push();
        test_start_empty_and_busy();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vector_instruction_issuer.md
Name: vector_instruction_issuer

Overview:
- Front-end sequencer that produces the 13-bit instruction stream consumed by the vector processor.
- A host writes a program into an internal instruction FIFO. On start, the block issues each instruction, holding it stable for an opcode-dependent number of clocks so the processor's load/store/add/mul sequences complete before the next instruction is presented.
- Reports busy/done status and an issued-instruction count.

Parameters:
- DEPTH, 8, FIFO depth in instructions (power of 2, ≥2).
- LAT_LOAD, 2, clocks a load (opcode 00) is held on the instruction output (≥1).
- LAT_STORE, 2, clocks a store (opcode 01) is held (≥1).
- LAT_ADD, 3, clocks an add (opcode 10) is held (≥1).
- LAT_MUL, 3, clocks a mul (opcode 11) is held (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- prog_data  input  13  instruction to enqueue: [12:11] opcode, [10:9] register, [8:0] memory address.
- prog_valid  input  1  host push request.
- prog_ready  output  1  FIFO not full; push occurs when prog_valid && prog_ready.
- start  input  1  begin issuing queued instructions (sampled only in IDLE).
- instruction  output  13  instruction to the processor, registered.
- instr_valid  output  1  high while instruction carries an instruction being issued.
- busy  output  1  high in ISSUE/HOLD.
- done  output  1  one-cycle pulse when a run ends.
- issued_count  output  8  instructions issued since reset, wraps 255→0.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty, fifo_count=0, prog_ready=1.
  - instruction=13'h0000, instr_valid=0, busy=0, done=0, issued_count=0, state=IDLE.
  - Reset mid-run aborts immediately and discards the queue.
- FIFO:
  - Circular buffer with read/write pointers wrapping at DEPTH.
  - prog_ready = (fifo_count != DEPTH); there is no bypass when full.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Pushes are accepted in every state, including during a run.
- Hold latency: LAT(op) is selected from the opcode [12:11] of the popped instruction.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - start=1 with fifo_count>0 → pop head; next cycle instruction=head, instr_valid=1, busy=1; hold counter loads LAT(op)-1; go to ISSUE.
  - start=1 with fifo empty → done=1 for the next cycle only, no issue, stay in IDLE.
  - start=0 → remain in IDLE.
- ISSUE/HOLD:
  - The instruction is held exactly LAT(op) consecutive cycles (the ISSUE cycle plus LAT(op)-1 HOLD cycles).
  - On the last held cycle, if fifo_count>0 (including an entry pushed that same cycle? no: the count as registered), pop the next entry. The next instruction appears the following cycle with instr_valid staying high, so issue is back-to-back with no gap.
  - Otherwise, on the following cycle: instr_valid=0, busy=0, done=1 (one cycle), state=IDLE.
- instruction output:
  - Updates only on a pop.
  - Retains its last value after a run ends.
  - The processor has no valid input, so instruction must never glitch or change while instr_valid=1.
- issued_count increments by 1 in each cycle a new instruction first appears on instruction.
- start asserted while busy is ignored.
- done and a new start in the same cycle: start is sampled, because the state is already IDLE.

Test Plan:
- Reset: drive reset low mid-run → all outputs at reset values within the same cycle; fifo_count=0; start afterwards with empty queue gives done pulse only.
- Single load: push 13'h0205 (load r1, addr 5), start → instruction=0x0205 and instr_valid=1 for exactly 2 cycles; issued_count=1; done pulses the cycle after.
- Mixed latency back-to-back: push load 0x0000, store 0x0A10, add 0x1000, mul 0x1800, start → holds of 2,2,3,3 cycles; instr_valid continuously high for 10 cycles; issued_count=4; a single done.
- FIFO full/wrap: push 8 entries → prog_ready=0 and a 9th push is rejected; run, then push 5 more during the run → all 13 issued in push order; pointers wrap correctly.
- Simultaneous push/pop: push exactly on the pop cycle with fifo_count=3 → fifo_count stays 3; the pushed entry is issued last.
- start with empty FIFO, and start while busy → the first gives a one-cycle done with no instr_valid; the second has no effect on the sequence.
